// File: rtl/mos6502s_vector_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mos6502s_vector_fetch
//  Purpose  : Interrupt/reset vector sequencer in front of the program
//             counter. Arbitrates RESET > NMI > BRK > IRQ, reads the 2-byte
//             vector over a ready handshake and pulses pc_load/set_i with the
//             assembled address.
//  Options  : MOS6502S_IRQ_SYNC_EN - when defined, nmi_n_i and irq_n_i pass
//             through 2-flop synchronizers (reset to 1) before use.
//  Revision : 1.0 - initial release
// ============================================================================
module mos6502s_vector_fetch #(
  parameter logic [15:0] VEC_BASE       = 16'hFFFA,
  parameter bit          START_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_rst_req_i,
  input  logic        nmi_n_i,
  input  logic        irq_n_i,
  input  logic        irq_mask_i,
  input  logic        brk_req_i,
  input  logic        instr_boundary_i,
  output logic        mem_rd_o,
  output logic [15:0] mem_addr_o,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_ready_i,
  output logic        pc_load_o,
  output logic [15:0] pc_addr_o,
  output logic        set_i_o,
  output logic [1:0]  vec_kind_o,
  output logic        busy_o
);

  localparam logic [1:0] KIND_RST = 2'b00;
  localparam logic [1:0] KIND_NMI = 2'b01;
  localparam logic [1:0] KIND_IRQ = 2'b10;
  localparam logic [1:0] KIND_BRK = 2'b11;

  localparam logic [15:0] VEC_NMI = VEC_BASE;
  localparam logic [15:0] VEC_RST = VEC_BASE + 16'd2;
  localparam logic [15:0] VEC_IRQ = VEC_BASE + 16'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_RD_LO = 3'd2,
    ST_RD_HI = 3'd3,
    ST_LOAD  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  vec_kind_q, vec_kind_d;
  logic [15:0] vec_addr_q, vec_addr_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] pc_addr_q, pc_addr_d;
  logic        rst_pend_q, rst_pend_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic        brk_pend_q, brk_pend_d;
  logic        nmi_prev_q;
  logic        nmi_clr;
  logic        brk_clr;
  logic        nmi_lvl;
  logic        irq_lvl;
  logic        nmi_edge;
  logic        irq_active;

`ifdef MOS6502S_IRQ_SYNC_EN
  logic [1:0] nmi_sync_q;
  logic [1:0] irq_sync_q;

  // Two-stage synchronizers for the asynchronous interrupt lines (idle high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_sync_q <= 2'b11;
      irq_sync_q <= 2'b11;
    end else begin
      nmi_sync_q <= {nmi_sync_q[0], nmi_n_i};
      irq_sync_q <= {irq_sync_q[0], irq_n_i};
    end
  end

  assign nmi_lvl = nmi_sync_q[1];
  assign irq_lvl = irq_sync_q[1];
`else
  assign nmi_lvl = nmi_n_i;
  assign irq_lvl = irq_n_i;
`endif

  // NMI is a falling edge; IRQ is a level that the I flag can block.
  assign nmi_edge   = nmi_prev_q & ~nmi_lvl;
  assign irq_active = ~irq_lvl & ~irq_mask_i;
  assign busy_o     = (state_q != ST_IDLE);
  assign vec_kind_o = vec_kind_q;

  // State, pending flags and fetched vector bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vec_kind_q <= KIND_RST;
      vec_addr_q <= 16'h0000;
      lo_q       <= 8'h00;
      hi_q       <= 8'h00;
      pc_addr_q  <= 16'h0000;
      rst_pend_q <= START_ON_RESET;
      nmi_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      nmi_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      vec_kind_q <= vec_kind_d;
      vec_addr_q <= vec_addr_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      pc_addr_q  <= pc_addr_d;
      rst_pend_q <= rst_pend_d;
      nmi_pend_q <= nmi_pend_d;
      brk_pend_q <= brk_pend_d;
      nmi_prev_q <= nmi_lvl;
    end
  end

  // Next-state, arbitration and handshake outputs.
  always_comb begin
    state_d    = state_q;
    vec_kind_d = vec_kind_q;
    vec_addr_d = vec_addr_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    pc_addr_d  = pc_addr_q;
    rst_pend_d = rst_pend_q | cpu_rst_req_i;
    nmi_clr    = 1'b0;
    brk_clr    = 1'b0;
    mem_rd_o   = 1'b0;
    mem_addr_o = 16'h0000;
    pc_load_o  = 1'b0;
    set_i_o    = 1'b0;
    pc_addr_o  = pc_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rst_pend_q || cpu_rst_req_i ||
            (instr_boundary_i && (nmi_pend_q || brk_pend_q || irq_active))) begin
          state_d = ST_SEL;
        end
      end
      ST_SEL: begin
        state_d = ST_RD_LO;
        if (rst_pend_q || cpu_rst_req_i) begin
          vec_kind_d = KIND_RST;
          vec_addr_d = VEC_RST;
          rst_pend_d = 1'b0;
        end else if (nmi_pend_q) begin
          vec_kind_d = KIND_NMI;
          vec_addr_d = VEC_NMI;
          nmi_clr    = 1'b1;
        end else if (brk_pend_q) begin
          vec_kind_d = KIND_BRK;
          vec_addr_d = VEC_IRQ;
          brk_clr    = 1'b1;
        end else if (irq_active) begin
          vec_kind_d = KIND_IRQ;
          vec_addr_d = VEC_IRQ;
        end else begin
          // IRQ went away before arbitration: nothing to fetch.
          state_d = ST_IDLE;
        end
      end
      ST_RD_LO: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = vec_addr_q;
        if (cpu_rst_req_i) begin
          state_d = ST_SEL;
        end else if (mem_ready_i) begin
          lo_d    = mem_rdata_i;
          state_d = ST_RD_HI;
        end
      end
      ST_RD_HI: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = vec_addr_q + 16'd1;
        if (cpu_rst_req_i) begin
          state_d = ST_SEL;
        end else if (mem_ready_i) begin
          hi_d    = mem_rdata_i;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (cpu_rst_req_i) begin
          state_d = ST_SEL;
        end else begin
          pc_load_o = 1'b1;
          set_i_o   = 1'b1;
          pc_addr_o = {hi_q, lo_q};
          pc_addr_d = {hi_q, lo_q};
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new event arriving in the cycle its flag is consumed wins.
    nmi_pend_d = (nmi_pend_q & ~nmi_clr) | nmi_edge;
    brk_pend_d = (brk_pend_q & ~brk_clr) | brk_req_i;
  end

endmodule
`default_nettype wire
